ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_slave_mem.sv | 140 ++++++++++++++
 tb/tb_ahb_slave_mem.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a small word-addressed memory.
// It has programmable wait states and gives a two-cycle ERROR for out-of-range, oversized or misaligned beats.
//
// state | meaning
// IDLE  | ready; also the final (HREADYOUT=1) cycle of an OKAY data phase when ph_active
// WAIT  | inserted wait cycles of a legal transfer, timed by the wait_cnt down-counter
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high; a new transfer may be accepted here
module ahb_slave_mem #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [HDATA_SIZE-1:0] HRDATA
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
    state_t state;

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];
    logic [1:0]            wait_cnt;
    logic                  ph_active;
    logic                  ph_write;
    logic [IDX_W-1:0]      ph_idx;
    logic [1:0]            ph_off;
    logic [1:0]            ph_size;

    logic                  accept;
    logic                  bad_idx;
    logic                  addr_err;
    logic                  commit;
    logic [IDX_W-1:0]      a_idx;
    logic [3:0]            lane_mask;
    logic [HDATA_SIZE-1:0] wr_merge;
    logic [HDATA_SIZE-1:0] rd_fwd;
    logic                  unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // New address phases are only taken while this slave is driving HREADYOUT high.
    assign accept  = HSEL && HREADY && HTRANS[1] && (state == S_IDLE || state == S_ERR2);
    assign a_idx   = HADDR[IDX_W+1:2];
    assign bad_idx = HADDR[HADDR_SIZE-1:2] >= (HADDR_SIZE-2)'(MEM_DEPTH);
    assign addr_err = bad_idx || (HSIZE > 3'd2)
                    || (HSIZE == 3'd1 && HADDR[0])
                    || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    assign commit  = (state == S_IDLE) && ph_active && ph_write;

    // Memory words are 32 bits wide, so there are four little-endian byte lanes.
    always_comb begin
        lane_mask = 4'b0000;
        case (ph_size)
            2'd0:    lane_mask = 4'b0001 << ph_off;
            2'd1:    lane_mask = ph_off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        wr_merge = mem[ph_idx];
        for (int b = 0; b < 4; b++) begin
            if (lane_mask[b]) wr_merge[8*b +: 8] = HWDATA[8*b +: 8];
        end
    end

    // With zero wait states, a read can load HRDATA at the same edge that commits the previous write.
    assign rd_fwd = (commit && ph_idx == a_idx) ? wr_merge : mem[a_idx];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            wait_cnt  <= '0;
            ph_active <= 1'b0;
            ph_write  <= 1'b0;
            ph_idx    <= '0;
            ph_off    <= '0;
            ph_size   <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (commit) mem[ph_idx] <= wr_merge;
            case (state)
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 2'd1;
                    if (wait_cnt == 2'd1) begin
                        state     <= S_IDLE;
                        HREADYOUT <= 1'b1;
                        HRDATA    <= ph_write ? '0 : mem[ph_idx];
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    HREADYOUT <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    HRDATA    <= '0;
                    ph_active <= 1'b0;
                    if (accept) begin
                        if (addr_err) begin
                            state     <= S_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else begin
                            ph_active <= 1'b1;
                            ph_write  <= HWRITE;
                            ph_idx    <= a_idx;
                            ph_off    <= HADDR[1:0];
                            ph_size   <= HSIZE[1:0];
                            wait_cnt  <= 2'(WAIT_STATES);
                            if (WAIT_STATES == 0) begin
                                HRDATA <= HWRITE ? '0 : rd_fwd;
                            end else begin
                                state     <= S_WAIT;
                                HREADYOUT <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Testbench for ahb_slave_mem: two instances (0 and 1 wait states) checked against an array-based memory model.
// Directed protocol cases are followed by randomized single transfers.
module tb_ahb_slave_mem;
    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        hsel;
    logic        hwrite;
    logic        hmastlock;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hready_block;
    logic        cur;

    logic        rdy0, resp0, rdy1, resp1;
    logic [31:0] rdata0, rdata1;
    logic        obs_ready, obs_resp;
    logic [31:0] obs_rdata;

    logic [31:0] model [2][16];
    int          n_total = 0;
    int          n_pass  = 0;

    always #5 HCLK = ~HCLK;

    assign obs_ready = cur ? rdy1 : rdy0;
    assign obs_resp  = cur ? resp1 : resp0;
    assign obs_rdata = cur ? rdata1 : rdata0;

    ahb_slave_mem #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(16), .WAIT_STATES(0)) u_dut_ws0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && !cur), .HADDR(haddr), .HWDATA(hwdata),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HMASTLOCK(hmastlock), .HREADY(rdy0 && !hready_block),
        .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0));

    ahb_slave_mem #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(16), .WAIT_STATES(1)) u_dut_ws1 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && cur), .HADDR(haddr), .HWDATA(hwdata),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HMASTLOCK(hmastlock), .HREADY(rdy1 && !hready_block),
        .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rdata1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic bit exp_err(input logic [31:0] addr, input logic [2:0] size);
        if (addr / 4 >= 16) return 1'b1;
        if (size > 2) return 1'b1;
        if (addr % (32'd1 << size) != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_write(input int inst, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] data);
        int idx;
        int first;
        int n;
        idx   = int'(addr / 4);
        first = int'(addr % 4);
        n     = 1 << size;
        for (int b = first; b < first + n; b++) model[inst][idx][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++) model[i][j] = '0;
    endtask

    // One non-pipelined transfer: address phase, then data phase with HTRANS=IDLE.
    task automatic xfer(input int inst, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [1:0] trans);
        bit          err;
        int          exp_low;
        int          low;
        bit          done;
        logic [31:0] exp_rd;
        err     = exp_err(addr, size);
        exp_low = err ? 1 : ((inst == 1) ? 1 : 0);
        exp_rd  = err ? 32'h0 : model[inst][int'(addr / 4)];
        @(negedge HCLK);
        cur = (inst != 0); hsel = 1'b1; htrans = trans; haddr = addr; hwrite = wr; hsize = size;
        hburst = 3'($urandom_range(0, 7)); hprot = 4'($urandom_range(0, 15));
        hmastlock = 1'($urandom_range(0, 1));
        @(posedge HCLK); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
        low = 0; done = 0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge HCLK);
            if (!obs_ready) begin
                low++;
                chk("resp_wait", 32'(obs_resp), 32'(err));
                chk("rdata_wait", obs_rdata, 32'h0);
            end else begin
                done = 1;
                chk("resp_final", 32'(obs_resp), 32'(err));
                if (!err && !wr) chk("rdata", obs_rdata, exp_rd);
            end
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        chk("wait_cycles", 32'(low), 32'(exp_low));
        if (!err && wr) model_write(inst, addr, size, wdata);
        @(posedge HCLK); #1;
    endtask

    // Bus activity that must not be accepted: HREADYOUT stays high, OKAY, no read data.
    task automatic probe(input string tag, input logic sel, input logic [1:0] trans, input logic blk);
        @(negedge HCLK);
        cur = 1'b1; hsel = sel; htrans = trans; haddr = 32'h4; hwrite = 1'b1; hsize = 3'd2;
        hwdata = 32'h1234_5678; hready_block = blk;
        @(posedge HCLK); #1;
        hsel = 1'b0; htrans = 2'b00; hready_block = 1'b0;
        @(negedge HCLK);
        chk({tag, "_rdy"}, 32'(obs_ready), 32'd1);
        chk({tag, "_resp"}, 32'(obs_resp), 32'd0);
        chk({tag, "_rdata"}, obs_rdata, 32'h0);
        @(posedge HCLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          r_inst;
        logic [31:0] r_addr;
        logic [31:0] r_data;
        logic [2:0]  r_size;
        logic        r_wr;
        logic [1:0]  r_trans;

        HRESET = 1'b1; hsel = 1'b0; hwrite = 1'b0; hmastlock = 1'b0; haddr = '0; hwdata = '0;
        hsize = '0; hburst = '0; hprot = '0; htrans = 2'b00; hready_block = 1'b0; cur = 1'b1;
        model_clear();
        @(negedge HCLK);
        chk("rst_rdy0", 32'(rdy0), 32'd1);
        chk("rst_rdy1", 32'(rdy1), 32'd1);
        chk("rst_resp1", 32'(resp1), 32'd0);
        chk("rst_rdata1", rdata1, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;

        // Word write / read with one wait state.
        xfer(1, 1'b1, 32'h4, 3'd2, 32'hDEAD_BEEF, 2'b10);
        xfer(1, 1'b0, 32'h4, 3'd2, 32'h0, 2'b10);
        chk("rd_after_wr_0x4", model[1][1], 32'hDEAD_BEEF);

        // Zero wait states: byte write then back-to-back read of the same word.
        @(negedge HCLK);
        cur = 1'b0; hsel = 1'b1; htrans = 2'b10; haddr = 32'h9; hwrite = 1'b1; hsize = 3'd0;
        @(posedge HCLK); #1;
        haddr = 32'h8; hwrite = 1'b0; hsize = 3'd2; hwdata = 32'h0000_AA00;
        @(negedge HCLK);
        chk("b2b_wr_rdy", 32'(obs_ready), 32'd1);
        chk("b2b_wr_resp", 32'(obs_resp), 32'd0);
        model_write(0, 32'h9, 3'd0, 32'h0000_AA00);
        @(posedge HCLK); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge HCLK);
        chk("b2b_rd_rdy", 32'(obs_ready), 32'd1);
        chk("b2b_rd_data", obs_rdata, 32'h0000_AA00);
        @(posedge HCLK); #1;

        // Error responses, with memory left untouched.
        xfer(1, 1'b1, 32'h0, 3'd2, 32'h1122_3344, 2'b10);
        xfer(1, 1'b0, 32'h40, 3'd2, 32'h0, 2'b10);
        xfer(1, 1'b1, 32'h2, 3'd2, 32'hFFFF_FFFF, 2'b10);
        xfer(1, 1'b1, 32'h0, 3'd3, 32'hFFFF_FFFF, 2'b11);
        xfer(1, 1'b1, 32'h1, 3'd1, 32'hFFFF_FFFF, 2'b10);
        xfer(1, 1'b0, 32'h0, 3'd2, 32'h0, 2'b10);
        xfer(1, 1'b0, 32'h4, 3'd2, 32'h0, 2'b10);

        // Non-accepted bus activity, then confirm word 1 still holds its value.
        probe("busy", 1'b1, 2'b01, 1'b0);
        probe("nosel", 1'b0, 2'b10, 1'b0);
        probe("nordy", 1'b1, 2'b10, 1'b1);
        xfer(1, 1'b0, 32'h4, 3'd2, 32'h0, 2'b10);

        for (int n = 0; n < 60; n++) begin
            r_inst  = int'($urandom_range(0, 1));
            r_size  = 3'($urandom_range(0, 3));
            r_addr  = 32'($urandom_range(0, 'h47));
            if ($urandom_range(0, 1) == 1 && r_size < 3) r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
            r_wr    = 1'($urandom_range(0, 1));
            r_data  = $urandom;
            r_trans = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
            repeat ($urandom_range(0, 2)) @(posedge HCLK);
            xfer(r_inst, r_wr, r_addr, r_size, r_data, r_trans);
        end

        // Reset during the wait cycle of a write aborts it.
        @(negedge HCLK);
        cur = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0000_0055;
        @(negedge HCLK);
        chk("rst_mid_wait", 32'(obs_ready), 32'd0);
        HRESET = 1'b1;
        #1;
        chk("rst_mid_rdy", 32'(obs_ready), 32'd1);
        chk("rst_mid_resp", 32'(obs_resp), 32'd0);
        chk("rst_mid_rdata", obs_rdata, 32'h0);
        model_clear();
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        xfer(1, 1'b0, 32'h0, 3'd2, 32'h0, 2'b10);
        xfer(0, 1'b0, 32'h8, 3'd2, 32'h0, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
